// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: control inputs and serial outputs of the pattern generator.
interface seq_pattern_gen_if #(parameter int W = 16);
    localparam int LW = $clog2(W);
    logic          start;
    logic          abort;
    logic [W-1:0]  pattern;
    logic [LW-1:0] len;
    logic [3:0]    rep;
    logic          dout;
    logic          dout_vld;
    logic          frame_start;
    logic          busy;
    logic          done;
    modport master (output start, abort, pattern, len, rep,
                    input dout, dout_vld, frame_start, busy, done);
    modport slave  (input start, abort, pattern, len, rep,
                    output dout, dout_vld, frame_start, busy, done);
endinterface

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serialises a captured bit pattern MSB-first, repeated rep+1 times with GAP idle cycles between copies.
module seq_pattern_gen #(
    parameter int   W          = 16,
    parameter int   GAP        = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    seq_pattern_gen_if.slave bus
);
    localparam int         LW = $clog2(W);
    localparam logic [3:0] GL = 4'(GAP == 0 ? 0 : GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

    state_t        state;
    logic [W-1:0]  sh;
    logic [LW-1:0] sl, idx, len_c;
    logic [3:0]    rc, gc;

    // Lengths beyond the register are clamped so the index never leaves the pattern.
    assign len_c = (32'(bus.len) > W - 1) ? LW'(W - 1) : bus.len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            sh              <= '0;
            sl              <= '0;
            idx             <= '0;
            rc              <= '0;
            gc              <= '0;
            bus.dout        <= IDLE_LEVEL;
            bus.dout_vld    <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else if (bus.abort) begin
            state           <= S_IDLE;
            bus.dout        <= IDLE_LEVEL;
            bus.dout_vld    <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state           <= S_SHIFT;
                    sh              <= bus.pattern;
                    sl              <= len_c;
                    idx             <= len_c;
                    rc              <= bus.rep;
                    bus.dout        <= bus.pattern[len_c];
                    bus.dout_vld    <= 1'b1;
                    bus.frame_start <= 1'b1;
                    bus.busy        <= 1'b1;
                end
                S_SHIFT: if (idx != '0) begin
                    idx             <= idx - 1'b1;
                    bus.dout        <= sh[idx - 1'b1];
                    bus.frame_start <= 1'b0;
                end else if (rc == '0) begin
                    state           <= S_DONE;
                    bus.dout        <= IDLE_LEVEL;
                    bus.dout_vld    <= 1'b0;
                    bus.frame_start <= 1'b0;
                    bus.done        <= 1'b1;
                end else begin
                    rc <= rc - 1'b1;
                    // Without a gap the next copy starts on the very next cycle.
                    if (GAP == 0) begin
                        idx             <= sl;
                        bus.dout        <= sh[sl];
                        bus.frame_start <= 1'b1;
                    end else begin
                        state           <= S_GAP;
                        gc              <= GL;
                        bus.dout        <= IDLE_LEVEL;
                        bus.dout_vld    <= 1'b0;
                        bus.frame_start <= 1'b0;
                    end
                end
                S_GAP: if (gc == '0) begin
                    state           <= S_SHIFT;
                    idx             <= sl;
                    bus.dout        <= sh[sl];
                    bus.dout_vld    <= 1'b1;
                    bus.frame_start <= 1'b1;
                end else begin
                    gc <= gc - 1'b1;
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed scenarios on a GAP=1 instance (idle low) and a GAP=0 instance (idle high).
module tb_seq_pattern_gen;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_pattern_gen_if #(.W(16)) if1 ();
    seq_pattern_gen_if #(.W(16)) if0 ();

    seq_pattern_gen #(.W(16), .GAP(1), .IDLE_LEVEL(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    seq_pattern_gen #(.W(16), .GAP(0), .IDLE_LEVEL(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    int tests = 0;
    int fails = 0;
    logic [63:0] b;
    int nv, nfs, nd, nb, ng, fi, di;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles from the start edge; scrambles the inputs right after capture.
    task automatic collect(input bit sel, input int n);
        logic v, d, f, dn, bs;
        b = '0; nv = 0; nfs = 0; nd = 0; nb = 0; ng = 0; fi = -1; di = -1;
        for (int i = 0; i < n; i++) begin
            tick;
            if (i == 0) begin
                if (sel) begin
                    if1.start = 0; if1.pattern = ~if1.pattern; if1.len = 2; if1.rep = 5;
                end else begin
                    if0.start = 0; if0.pattern = ~if0.pattern; if0.len = 2; if0.rep = 5;
                end
            end
            v  = sel ? if1.dout_vld    : if0.dout_vld;
            d  = sel ? if1.dout        : if0.dout;
            f  = sel ? if1.frame_start : if0.frame_start;
            dn = sel ? if1.done        : if0.done;
            bs = sel ? if1.busy        : if0.busy;
            if (v) begin b = {b[62:0], d}; nv++; end
            if (f) begin nfs++; if (fi < 0) fi = i; end
            if (dn) begin nd++; di = i; end
            if (bs) nb++;
            if (bs && !v && !dn) ng++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        tests++; if ({if1.dout, if1.dout_vld, if1.frame_start, if1.busy, if1.done} !== 5'b00000) begin
            fails++; $display("FAIL reset_gap1 got %b want 00000", {if1.dout, if1.dout_vld, if1.frame_start, if1.busy, if1.done}); end
        tests++; if ({if0.dout, if0.dout_vld, if0.frame_start, if0.busy, if0.done} !== 5'b10000) begin
            fails++; $display("FAIL reset_gap0 got %b want 10000", {if0.dout, if0.dout_vld, if0.frame_start, if0.busy, if0.done}); end
        tick; tick;
        rst_n = 1'b1;
        tick; tick;
        tests++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL idle_no_start busy got %b want 0", if1.busy); end
    endtask

    task automatic test_single;
        if1.pattern = 16'h00B5; if1.len = 7; if1.rep = 0; if1.start = 1;
        collect(1, 12);
        tests++; if (b !== 64'hB5) begin fails++; $display("FAIL single_bits got %0h want b5", b); end
        tests++; if (nv !== 8) begin fails++; $display("FAIL single_valid got %0d want 8", nv); end
        tests++; if (nfs !== 1 || fi !== 0) begin fails++; $display("FAIL single_fs got %0d@%0d want 1@0", nfs, fi); end
        tests++; if (nd !== 1 || di !== 8) begin fails++; $display("FAIL single_done got %0d@%0d want 1@8", nd, di); end
        tests++; if (nb !== 9) begin fails++; $display("FAIL single_busy got %0d want 9", nb); end
    endtask

    task automatic test_repeat;
        if1.pattern = 16'h000D; if1.len = 3; if1.rep = 2; if1.start = 1;
        collect(1, 20);
        tests++; if (b !== 64'hDDD) begin fails++; $display("FAIL repeat_bits got %0h want ddd", b); end
        tests++; if (nv !== 12) begin fails++; $display("FAIL repeat_valid got %0d want 12", nv); end
        tests++; if (nfs !== 3) begin fails++; $display("FAIL repeat_fs got %0d want 3", nfs); end
        tests++; if (ng !== 2) begin fails++; $display("FAIL repeat_gaps got %0d want 2", ng); end
        tests++; if (nd !== 1 || di !== 14) begin fails++; $display("FAIL repeat_done got %0d@%0d want 1@14", nd, di); end
        tests++; if (nb !== 15) begin fails++; $display("FAIL repeat_busy got %0d want 15", nb); end
    endtask

    task automatic test_gap0;
        if0.pattern = 16'h0002; if0.len = 1; if0.rep = 3; if0.start = 1;
        collect(0, 12);
        tests++; if (b !== 64'hAA) begin fails++; $display("FAIL gap0_bits got %0h want aa", b); end
        tests++; if (nv !== 8 || ng !== 0) begin fails++; $display("FAIL gap0_cont got %0d/%0d want 8/0", nv, ng); end
        tests++; if (nfs !== 4) begin fails++; $display("FAIL gap0_fs got %0d want 4", nfs); end
        tests++; if (nd !== 1 || di !== 8) begin fails++; $display("FAIL gap0_done got %0d@%0d want 1@8", nd, di); end
        tests++; if (if0.dout !== 1'b1) begin fails++; $display("FAIL gap0_idle_level got %b want 1", if0.dout); end
    endtask

    task automatic test_abort;
        if1.pattern = 16'h00B5; if1.len = 7; if1.rep = 0; if1.start = 1;
        tick; if1.start = 0;
        tick; tick;
        tests++; if ({if1.dout_vld, if1.dout} !== 2'b11) begin fails++; $display("FAIL abort_third_bit got %b want 11", {if1.dout_vld, if1.dout}); end
        if1.abort = 1;
        tick; if1.abort = 0;
        tests++; if ({if1.dout_vld, if1.busy, if1.done, if1.dout} !== 4'b0000) begin
            fails++; $display("FAIL abort_idle got %b want 0000", {if1.dout_vld, if1.busy, if1.done, if1.dout}); end
        tick;
        tests++; if (if1.done !== 1'b0 || if1.busy !== 1'b0) begin fails++; $display("FAIL abort_no_done got %b%b want 00", if1.done, if1.busy); end
        tick;
        if1.pattern = 16'h005A; if1.start = 1;
        collect(1, 12);
        tests++; if (b !== 64'h5A || nv !== 8) begin fails++; $display("FAIL abort_fresh got %0h/%0d want 5a/8", b, nv); end
        tests++; if (nd !== 1) begin fails++; $display("FAIL abort_fresh_done got %0d want 1", nd); end
        if1.start = 1; if1.abort = 1;
        tick; if1.start = 0; if1.abort = 0;
        tests++; if (if1.busy !== 1'b0 || if1.dout_vld !== 1'b0) begin fails++; $display("FAIL abort_priority got %b%b want 00", if1.busy, if1.dout_vld); end
    endtask

    task automatic test_start_held;
        if1.pattern = 16'h0001; if1.len = 0; if1.rep = 0; if1.start = 1;
        tick;
        tests++; if ({if1.dout_vld, if1.frame_start, if1.dout, if1.busy} !== 4'b1111) begin
            fails++; $display("FAIL held_frame1 got %b want 1111", {if1.dout_vld, if1.frame_start, if1.dout, if1.busy}); end
        if1.pattern = 16'h0000;
        tick;
        tests++; if ({if1.done, if1.dout_vld, if1.busy, if1.dout} !== 4'b1010) begin
            fails++; $display("FAIL held_done got %b want 1010", {if1.done, if1.dout_vld, if1.busy, if1.dout}); end
        tick;
        tests++; if ({if1.busy, if1.done, if1.dout_vld} !== 3'b000) begin
            fails++; $display("FAIL held_idle got %b want 000", {if1.busy, if1.done, if1.dout_vld}); end
        tick;
        tests++; if ({if1.dout_vld, if1.frame_start, if1.dout, if1.busy} !== 4'b1101) begin
            fails++; $display("FAIL held_frame2 got %b want 1101", {if1.dout_vld, if1.frame_start, if1.dout, if1.busy}); end
        if1.start = 0;
        tick;
        tests++; if (if1.done !== 1'b1) begin fails++; $display("FAIL held_done2 got %b want 1", if1.done); end
        tick;
    endtask

    task automatic test_async_reset;
        if1.pattern = 16'h000D; if1.len = 3; if1.rep = 2; if1.start = 1;
        tick; if1.start = 0;
        tick; tick; tick; tick;
        tests++; if ({if1.dout_vld, if1.busy} !== 2'b01) begin fails++; $display("FAIL in_gap got %b want 01", {if1.dout_vld, if1.busy}); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({if1.dout, if1.dout_vld, if1.frame_start, if1.busy, if1.done} !== 5'b00000) begin
            fails++; $display("FAIL async_reset got %b want 00000", {if1.dout, if1.dout_vld, if1.frame_start, if1.busy, if1.done}); end
        #2 rst_n = 1'b1;
        tick; tick;
        tests++; if (if1.busy !== 1'b0 || if1.done !== 1'b0) begin fails++; $display("FAIL post_reset_idle got %b%b want 00", if1.busy, if1.done); end
        if1.pattern = 16'h00B5; if1.len = 7; if1.rep = 1; if1.start = 1;
        collect(1, 24);
        tests++; if (b !== 64'hB5B5 || nv !== 16) begin fails++; $display("FAIL post_reset_bits got %0h/%0d want b5b5/16", b, nv); end
        tests++; if (nfs !== 2 || ng !== 1) begin fails++; $display("FAIL post_reset_fs_gap got %0d/%0d want 2/1", nfs, ng); end
        tests++; if (nd !== 1 || di !== 17) begin fails++; $display("FAIL post_reset_done got %0d@%0d want 1@17", nd, di); end
    endtask

    initial begin
        if1.start = 0; if1.abort = 0; if1.pattern = '0; if1.len = '0; if1.rep = '0;
        if0.start = 0; if0.abort = 0; if0.pattern = '0; if0.len = '0; if0.rep = '0;
        test_reset;
        test_single;
        test_repeat;
        test_gap0;
        test_abort;
        test_start_held;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
